// File: rtl/m31_inv_sbox.sv
// Inverse Poseidon2 S-box over M31: y = x^D mod (2^31-1), D = 0x66666665,
// by left-to-right square-and-multiply on one pipelined modular multiplier.
module m31_inv_sbox #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_data
);

    localparam logic [30:0] D_EXP   = 31'h6666_6665;
    localparam logic [30:0] M31_P   = 31'h7FFF_FFFF;
    localparam int          N_OPS   = 45;
    localparam int          PIPE_N  = MUL_LAT - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Folds a 62-bit product into the canonical range [0, p-1].
    function automatic logic [30:0] m31_reduce(input logic [61:0] prod);
        logic [31:0] sum;
        logic [30:0] fold;
        sum  = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
        fold = sum[30:0] + {30'd0, sum[31]};
        return (fold == M31_P) ? 31'd0 : fold;
    endfunction

    state_t      state_r;
    logic [30:0] x_r;
    logic [30:0] acc_r;
    logic [4:0]  bit_r;
    logic        phase_mul_r;
    logic [5:0]  op_cnt_r;
    logic [7:0]  wait_cnt_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [30:0] out_data_r;

    logic [30:0] mul_a_last_r;
    logic [30:0] mul_b_last_r;
    logic [30:0] mul_a_s;
    logic [30:0] mul_b_s;
    logic [30:0] mul_res_s;
    logic [30:0] pipe_r [PIPE_N];
    logic        d_bit_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign mul_res_s = pipe_r[PIPE_N-1];
    assign d_bit_s   = D_EXP[bit_r];

    // Multiplier operand select: live operands in ISSUE, last issued pair otherwise.
    always_comb begin
        mul_a_s = mul_a_last_r;
        mul_b_s = mul_b_last_r;
        if (state_r == ISSUE) begin
            mul_a_s = acc_r;
            mul_b_s = phase_mul_r ? x_r : acc_r;
        end else begin
            mul_a_s = mul_a_last_r;
            mul_b_s = mul_b_last_r;
        end
    end

    // Modular multiplier pipeline; result is usable MUL_LAT cycles after issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_r[i] <= 31'd0;
            end
        end else begin
            pipe_r[0] <= m31_reduce({31'd0, mul_a_s} * {31'd0, mul_b_s});
            for (int i = 1; i < PIPE_N; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Control FSM, exponent walk and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            x_r          <= 31'd0;
            acc_r        <= 31'd0;
            bit_r        <= 5'd0;
            phase_mul_r  <= 1'b0;
            op_cnt_r     <= 6'd0;
            wait_cnt_r   <= 8'd0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_data_r   <= 31'd0;
            mul_a_last_r <= 31'd0;
            mul_b_last_r <= 31'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x_r         <= in_data;
                        acc_r       <= in_data;
                        bit_r       <= 5'd29;
                        phase_mul_r <= 1'b0;
                        op_cnt_r    <= 6'd0;
                        in_ready_r  <= 1'b0;
                        state_r     <= ISSUE;
                    end else begin
                        in_ready_r  <= 1'b1;
                    end
                end
                ISSUE: begin
                    mul_a_last_r <= mul_a_s;
                    mul_b_last_r <= mul_b_s;
                    wait_cnt_r   <= 8'd0;
                    state_r      <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_r == 8'(MUL_LAT - 2)) begin
                        acc_r    <= mul_res_s;
                        op_cnt_r <= op_cnt_r + 6'd1;
                        // A set exponent bit adds a multiply-by-x after its squaring.
                        if (!phase_mul_r && d_bit_s) begin
                            phase_mul_r <= 1'b1;
                        end else begin
                            phase_mul_r <= 1'b0;
                            bit_r       <= bit_r - 5'd1;
                        end
                        if (op_cnt_r == 6'(N_OPS - 1)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= ISSUE;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= acc_r;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
